// File: rtl/seq_detect_rr_scheduler.sv
// Shared "1011" Moore detector time-multiplexed over NUM_CH serial streams.
// Round-robin grant, per-channel saved context and saturating match counts.
module seq_detect_rr_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  output logic [NUM_CH-1:0] ch_ready,
  input  logic              clear_ch,
  input  logic [CH_W-1:0]   clear_id,
  output logic              det_valid,
  output logic [CH_W-1:0]   det_ch,
  input  logic [CH_W-1:0]   rd_id,
  output logic [CNT_W-1:0]  rd_cnt
);

  typedef enum logic [4:0] {
    ZERO         = 5'b00001,
    ONE          = 5'b00010,
    ONE_ZERO     = 5'b00100,
    ONE_ZERO_ONE = 5'b01000,
    DETECT       = 5'b10000
  } state_t;

  function automatic state_t next_state(state_t s, logic b);
    case (s)
      ZERO:         return b ? ONE : ZERO;
      ONE:          return b ? ONE : ONE_ZERO;
      ONE_ZERO:     return b ? ONE_ZERO_ONE : ZERO;
      ONE_ZERO_ONE: return b ? DETECT : ONE_ZERO;
      DETECT:       return b ? ONE : ONE_ZERO;
      default:      return ZERO;
    endcase
  endfunction

  function automatic logic [CH_W-1:0] wrap(int v);
    return CH_W'(v % NUM_CH);
  endfunction

  state_t           ctx [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  gnt_id;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] grant;
  logic             xfer;
  logic             clr_ok;
  state_t           nxt;

  assign clr_ok = clear_ch && (int'(clear_id) < NUM_CH);

  // Walk from farthest to nearest so the first channel after ptr wins.
  always_comb begin
    elig = ch_valid;
    if (clr_ok) elig[clear_id] = 1'b0;
    grant  = '0;
    gnt_id = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (elig[wrap(int'(ptr) + k)]) begin
        grant = '0;
        grant[wrap(int'(ptr) + k)] = 1'b1;
        gnt_id = wrap(int'(ptr) + k);
      end
    end
  end

  assign ch_ready = grant;
  assign xfer     = |grant;
  assign nxt      = next_state(ctx[gnt_id], ch_bit[gnt_id]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr       <= CH_W'(NUM_CH - 1);
      det_valid <= 1'b0;
      det_ch    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ctx[i] <= ZERO;
        cnt[i] <= '0;
      end
    end else begin
      det_valid <= 1'b0;
      if (clr_ok) begin
        ctx[clear_id] <= ZERO;
        cnt[clear_id] <= '0;
      end
      if (xfer) begin
        ptr         <= gnt_id;
        ctx[gnt_id] <= nxt;
        if (nxt == DETECT) begin
          det_valid <= 1'b1;
          det_ch    <= gnt_id;
          if (cnt[gnt_id] != '1)
            cnt[gnt_id] <= cnt[gnt_id] + 1'b1;
        end
      end
    end
  end

  assign rd_cnt = (int'(rd_id) < NUM_CH) ? cnt[rd_id] : '0;

endmodule
